// File: rtl/time_counter_pkg.sv
// Shared definitions for the time_counter block: mode encoding, BCD field
// limits and the per-mode blink masks.
package time_counter_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    // Two-digit BCD limits, written as {tens, ones}.
    localparam logic [7:0] BCD_MAX_59 = 8'h59;
    localparam logic [7:0] BCD_MAX_23 = 8'h23;
    localparam logic [7:0] BCD_MAX_12 = 8'h12;
    localparam logic [7:0] BCD_ZERO   = 8'h00;
    localparam logic [7:0] BCD_ONE    = 8'h01;
    localparam logic [7:0] BCD_ELEVEN = 8'h11;

    // Blink masks; bit 5 = hour_tens ... bit 0 = sec_ones.
    localparam logic [5:0] FLASH_RUN  = 6'b000000;
    localparam logic [5:0] FLASH_HOUR = 6'b110000;
    localparam logic [5:0] FLASH_MIN  = 6'b001100;
    localparam logic [5:0] FLASH_SEC  = 6'b000011;

    function automatic logic [5:0] flash_for(input mode_t m);
        case (m)
            MODE_SET_HOUR: flash_for = FLASH_HOUR;
            MODE_SET_MIN:  flash_for = FLASH_MIN;
            MODE_SET_SEC:  flash_for = FLASH_SEC;
            default:       flash_for = FLASH_RUN;
        endcase
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Two-digit BCD field counter. Counts MIN..MAX and wraps MAX -> MIN.
// carry is a combinational pulse: inc while the field sits at MAX.
// clear reloads the reset value synchronously.
module bcd_counter #(
    parameter logic [7:0] MAX     = 8'h59,
    parameter logic [7:0] MIN     = 8'h00,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clear,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    logic at_max;

    assign at_max = ({tens, ones} == MAX);
    assign carry  = inc & at_max;

    // Field register: wrap at the limit, otherwise BCD ripple from ones to tens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= RST_VAL[7:4];
            ones <= RST_VAL[3:0];
        end else if (clear) begin
            tens <= RST_VAL[7:4];
            ones <= RST_VAL[3:0];
        end else if (inc) begin
            if (at_max) begin
                tens <= MIN[7:4];
                ones <= MIN[3:0];
            end else if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_counter.sv
// time_counter: 1 Hz prescaler, HH:MM:SS in BCD and a set-mode FSM.
// Optional feature: define TIME_COUNTER_12H_EN for a 12-hour clock with pm flag;
// default build is a 24-hour clock with pm tied low.
// Key strobes are single-cycle pulses; key_mode takes priority over key_inc.
module time_counter
    import time_counter_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [5:0] flash_sel,
    output logic       sec_tick,
    output logic       pm,
    output mode_t      mode_dbg
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ - 1);

`ifdef TIME_COUNTER_12H_EN
    localparam logic [7:0] HOUR_MAX = BCD_MAX_12;
    localparam logic [7:0] HOUR_MIN = BCD_ONE;
    localparam logic [7:0] HOUR_RST = BCD_MAX_12;
`else
    localparam logic [7:0] HOUR_MAX = BCD_MAX_23;
    localparam logic [7:0] HOUR_MIN = BCD_ZERO;
    localparam logic [7:0] HOUR_RST = BCD_ZERO;
`endif

    mode_t         mode, mode_next;
    logic [PW-1:0] presc;
    logic          tc;
    logic          inc_ok;
    logic          sec_inc, min_inc, hour_inc;
    logic          sec_carry, min_carry, hour_carry;

    assign tc     = (mode == MODE_RUN) && (presc == PRESC_TC);
    assign inc_ok = key_inc & ~key_mode;

    // Ticks ripple only in RUN; in SET modes tc is low so no carry leaks.
    assign sec_inc  = tc | (inc_ok && mode == MODE_SET_SEC);
    assign min_inc  = (tc & sec_carry) | (inc_ok && mode == MODE_SET_MIN);
    assign hour_inc = (tc & sec_carry & min_carry) | (inc_ok && mode == MODE_SET_HOUR);

    // Mode state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mode <= MODE_RUN;
        else      mode <= mode_next;
    end

    // Mode next-state and blink mask.
    always_comb begin
        mode_next = mode;
        flash_sel = flash_for(mode);
        if (key_mode) begin
            case (mode)
                MODE_RUN:      mode_next = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_next = MODE_SET_MIN;
                MODE_SET_MIN:  mode_next = MODE_SET_SEC;
                default:       mode_next = MODE_RUN;
            endcase
        end
    end

    assign mode_dbg = mode;

    // Prescaler: counts only in RUN, held at 0 while setting so RUN restarts a full second.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  presc <= '0;
        else if (mode != MODE_RUN) presc <= '0;
        else if (tc)               presc <= '0;
        else                       presc <= presc + PW'(1);
    end

    // One-cycle pulse aligned with the freshly updated digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sec_tick <= 1'b0;
        else      sec_tick <= tc;
    end

    bcd_counter #(.MAX(BCD_MAX_59), .MIN(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .clear (1'b0),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    bcd_counter #(.MAX(BCD_MAX_59), .MIN(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .clear (1'b0),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry)
    );

    bcd_counter #(.MAX(HOUR_MAX), .MIN(HOUR_MIN), .RST_VAL(HOUR_RST)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   (hour_inc),
        .clear (1'b0),
        .tens  (hour_tens),
        .ones  (hour_ones),
        .carry (hour_carry)
    );

`ifdef TIME_COUNTER_12H_EN
    logic hour_run_inc;
    assign hour_run_inc = tc & sec_carry & min_carry;

    // pm flips only when running time crosses 11:59:59 -> 12:00:00.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pm <= 1'b0;
        else if (hour_run_inc && {hour_tens, hour_ones} == BCD_ELEVEN)
            pm <= ~pm;
    end
`else
    assign pm = 1'b0;
`endif

    // The hour field has nothing to carry into.
    logic unused_carry;
    assign unused_carry = hour_carry;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with CLK_FREQ = 10.
// Valid/ready does not apply here: keys are one-cycle strobes sampled on the
// rising edge. Inputs change and outputs are sampled 1 ns after each edge.
module tb_time_counter;
    import time_counter_pkg::*;

    localparam int CLK_FREQ = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_mode = 1'b0;
    logic key_inc  = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic [5:0] flash_sel;
    logic       sec_tick, pm;
    mode_t      mode_dbg;

    logic [7:0]  hh, mm, ss;
    logic [23:0] hms;
    assign hh  = {hour_tens, hour_ones};
    assign mm  = {min_tens, min_ones};
    assign ss  = {sec_tens, sec_ones};
    assign hms = {hh, mm, ss};

    time_counter #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .hour_tens (hour_tens),
        .hour_ones (hour_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .flash_sel (flash_sel),
        .sec_tick  (sec_tick),
        .pm        (pm),
        .mode_dbg  (mode_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic saw_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (sec_tick) saw_tick = 1'b1;
    endtask

    task automatic press(input logic m, input logic i);
        key_mode = m;
        key_inc  = i;
        step();
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
    endtask

    // Cycles until sec_tick is seen; 50 means the bound expired.
    task automatic wait_tick(output int cyc);
        cyc = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            cyc++;
            if (sec_tick) break;
        end
    endtask

    int gap;

    initial begin
        saw_tick = 1'b0;
        #12;
`ifdef TIME_COUNTER_12H_EN
        // Reset state, 12-hour build.
        check("rst_time_12h", hms, 24'h120000);
        check("rst_pm", pm, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // SET_HOUR from 12: first inc wraps to 01, eleventh lands on 11; pm untouched.
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("set_hour_12_to_01", hh, 8'h01);
        inc_n(10);
        check("set_hour_11", hh, 8'h11);
        check("set_hour_pm", pm, 1'b0);
        press(1'b1, 1'b0);
        inc_n(59);
        press(1'b1, 1'b0);
        inc_n(59);
        check("preset_115959", hms, 24'h115959);
        press(1'b1, 1'b0);
        check("mode_run_12h", mode_dbg, MODE_RUN);
        wait_tick(gap);
        check("tick_gap_12h", gap, 10);
        check("wrap_to_12", hms, 24'h120000);
        check("wrap_pm", pm, 1'b1);
        wait_tick(gap);
        check("after_wrap", hms, 24'h120001);
        check("pm_hold", pm, 1'b1);
`else
        // Reset state, held in reset.
        check("rst_time", hms, 24'h000000);
        check("rst_flash", flash_sel, 6'b000000);
        check("rst_tick", sec_tick, 1'b0);
        check("rst_pm", pm, 1'b0);
        check("rst_mode", mode_dbg, MODE_RUN);
        @(posedge clk); #1;
        rst = 1'b1;

        // Ten ticks, each exactly 10 cycles apart.
        for (int t = 0; t < 10; t++) begin
            wait_tick(gap);
            check("tick_gap", gap, 10);
        end
        check("ten_secs", ss, 8'h10);

        // Preload 23:59:58 through the set modes.
        press(1'b1, 1'b0);
        check("flash_hour", flash_sel, 6'b110000);
        inc_n(23);
        press(1'b1, 1'b0);
        check("flash_min", flash_sel, 6'b001100);
        inc_n(59);
        press(1'b1, 1'b0);
        check("flash_sec", flash_sel, 6'b000011);
        inc_n(48);
        check("preset_235958", hms, 24'h235958);
        press(1'b1, 1'b0);
        check("flash_run", flash_sel, 6'b000000);
        wait_tick(gap);
        check("first_tick_after_set", gap, 10);
        check("time_235959", hms, 24'h235959);
        wait_tick(gap);
        check("full_wrap", hms, 24'h000000);

        // Hour set wraps past 23 with no carry and no ticks.
        saw_tick = 1'b0;
        press(1'b1, 1'b0);
        inc_n(25);
        check("hour_25_incs", hms, 24'h010000);
        check("flash_set_hour", flash_sel, 6'b110000);
        check("no_tick_in_set", saw_tick, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("back_to_run", mode_dbg, MODE_RUN);

        // key_mode and key_inc together: mode wins.
        press(1'b1, 1'b1);
        check("both_mode", mode_dbg, MODE_SET_HOUR);
        check("both_hours", hh, 8'h01);

        // Asynchronous reset in SET_MIN.
        press(1'b1, 1'b0);
        inc_n(7);
        check("set_min_07", mm, 8'h07);
        check("mode_set_min", mode_dbg, MODE_SET_MIN);
        rst = 1'b0;
        #2;
        check("async_rst_time", hms, 24'h000000);
        check("async_rst_flash", flash_sel, 6'b000000);
        check("async_rst_mode", mode_dbg, MODE_RUN);
        step();
        rst = 1'b1;

        // Terminal count coinciding with key_mode: tick first, then SET_HOUR.
        for (int k = 0; k < 9; k++) step();
        press(1'b1, 1'b0);
        check("tc_mode_sec", ss, 8'h01);
        check("tc_mode_tick", sec_tick, 1'b1);
        check("tc_mode_mode", mode_dbg, MODE_SET_HOUR);
        saw_tick = 1'b0;
        for (int k = 0; k < 20; k++) step();
        check("frozen_in_set", saw_tick, 1'b0);
        check("frozen_time", hms, 24'h000001);

        // key_inc in RUN is ignored.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("inc_in_run", hms, 24'h000001);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
